// File: rtl/scope_pkg.sv
// Shared types and helpers for the scope_checker comparator.
package scope_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_CHECK  = 2'd2,
      ST_DONE   = 2'd3
   } scope_state_t;

   // Bits needed to hold values 0..n-1, never less than 1.
   function automatic int clog2w(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

   // Add b to a, clamping at max_v instead of wrapping.
   function automatic logic [31:0] sat_add(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] max_v);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (s > {1'b0, max_v}) ? max_v : s[31:0];
   endfunction

endpackage

// File: rtl/scope_mismatch.sv
// Combinational reduction of a per-channel mismatch vector:
// popcount, lowest set index and an any-set flag.
module scope_mismatch
   import scope_pkg::*;
#(
   parameter int CHANNELS = 2,
   parameter int CH_W     = clog2w(CHANNELS),
   parameter int POP_W    = clog2w(CHANNELS + 1)
) (
   input  logic [CHANNELS-1:0] mm_i,
   output logic [POP_W-1:0]    pop_o,
   output logic [CH_W-1:0]     idx_o,
   output logic                any_o
);

   // Count set bits; scan from the top so the lowest set index wins.
   always_comb begin
      pop_o = '0;
      idx_o = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         pop_o = pop_o + POP_W'(mm_i[i]);
      end
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (mm_i[i]) idx_o = CH_W'(i);
      end
      any_o = |mm_i;
   end

endmodule

// File: rtl/scope_checker.sv
// Multi-channel timed comparator: after a settle delay, compares obs
// against exp for CHECK_CYCLES cycles and reports pass/fail, a saturating
// mismatch count and the first failing channel.
//
// state     | meaning
// ----------+------------------------------------------------------
// ST_IDLE   | waiting for start (ignored while the done pulse is high)
// ST_SETTLE | counting down SETTLE idle cycles
// ST_CHECK  | sampling obs vs exp each cycle, counting down CHECK_CYCLES
// ST_DONE   | one closing cycle; result and done pulse register on exit
module scope_checker
   import scope_pkg::*;
#(
   parameter int WIDTH        = 1,
   parameter int CHANNELS     = 2,
   parameter int SETTLE       = 1,
   parameter int CHECK_CYCLES = 4,
   parameter int CNT_W        = 8,
   localparam int CH_W        = clog2w(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [CHANNELS*WIDTH-1:0] obs,
   input  logic [CHANNELS*WIDTH-1:0] exp,
   output logic                      busy,
   output logic                      done,
   output logic                      pass,
   output logic [CNT_W-1:0]          err_count,
   output logic [CH_W-1:0]           first_chan,
   output logic                      first_valid
);

   localparam int TMAX  = (SETTLE > CHECK_CYCLES) ? SETTLE : CHECK_CYCLES;
   localparam int TW    = clog2w(TMAX);
   localparam int POP_W = clog2w(CHANNELS + 1);
   localparam logic [31:0] SAT_MAX = (32'd1 << CNT_W) - 32'd1;

   scope_state_t      state_q, state_d;
   logic [TW-1:0]     cnt_q, cnt_d;
   logic [CNT_W-1:0]  err_q, err_d;
   logic [CH_W-1:0]   fc_q, fc_d;
   logic              fv_q, fv_d;
   logic              pass_q, pass_d;
   logic              done_q, done_d;
   logic              accept, sample;

   logic [CHANNELS-1:0] mm;
   logic [POP_W-1:0]    pop;
   logic [CH_W-1:0]     idx;
   logic                any;

   // Case-inequality so X/Z on obs counts as a mismatch in simulation;
   // synthesis reduces it to a plain inequality.
   always_comb begin
      mm = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         mm[i] = (obs[i*WIDTH +: WIDTH] !== exp[i*WIDTH +: WIDTH]);
      end
   end

   scope_mismatch #(
      .CHANNELS (CHANNELS),
      .CH_W     (CH_W),
      .POP_W    (POP_W)
   ) u_mismatch (
      .mm_i  (mm),
      .pop_o (pop),
      .idx_o (idx),
      .any_o (any)
   );

   // State and run-counter next-state logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      sample  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start && !done_q) begin
               accept = 1'b1;
               if (SETTLE == 0) begin
                  state_d = ST_CHECK;
                  cnt_d   = TW'(CHECK_CYCLES - 1);
               end else begin
                  state_d = ST_SETTLE;
                  cnt_d   = TW'(SETTLE - 1);
               end
            end
         end
         ST_SETTLE: begin
            if (cnt_q == '0) begin
               state_d = ST_CHECK;
               cnt_d   = TW'(CHECK_CYCLES - 1);
            end else begin
               cnt_d = cnt_q - TW'(1);
            end
         end
         ST_CHECK: begin
            sample = 1'b1;
            if (cnt_q == '0) state_d = ST_DONE;
            else             cnt_d   = cnt_q - TW'(1);
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Result registers: cleared by an accepted start, accumulated while
   // checking, and resolved into pass/done on leaving ST_DONE.
   always_comb begin
      err_d  = err_q;
      fc_d   = fc_q;
      fv_d   = fv_q;
      pass_d = pass_q;
      done_d = (state_q == ST_DONE);
      if (accept) begin
         err_d  = '0;
         fc_d   = '0;
         fv_d   = 1'b0;
         pass_d = 1'b0;
      end else if (sample) begin
         err_d = CNT_W'(sat_add(32'(err_q), 32'(pop), SAT_MAX));
         if (any && !fv_q) begin
            fc_d = idx;
            fv_d = 1'b1;
         end
      end
      if (state_q == ST_DONE) pass_d = (err_q == '0);
   end

   // State and result registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         err_q   <= '0;
         fc_q    <= '0;
         fv_q    <= 1'b0;
         pass_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         fc_q    <= fc_d;
         fv_q    <= fv_d;
         pass_q  <= pass_d;
         done_q  <= done_d;
      end
   end

   // The done pulse cycle still counts as busy so a start there is ignored.
   assign busy        = (state_q != ST_IDLE) || done_q;
   assign done        = done_q;
   assign pass        = pass_q;
   assign err_count   = err_q;
   assign first_chan  = fc_q;
   assign first_valid = fv_q;

endmodule

// File: tb/tb_scope_checker.sv
module tb_scope_checker;

   logic clk = 1'b0;
   logic rst;
   logic start1, start4, start0;
   logic [15:0] obs_v, exp_v;

   always #5 clk = ~clk;

   // d1: WIDTH=1 CHANNELS=2 SETTLE=1
   logic busy1, done1, pass1, fv1;
   logic [7:0] err1;
   logic [0:0] fc1;
   // d4: WIDTH=4 CHANNELS=4 SETTLE=1 CNT_W=8
   logic busy4, done4, pass4, fv4;
   logic [7:0] err4;
   logic [1:0] fc4;
   // ds: same as d4 with CNT_W=3, shares start4
   logic busys, dones, passs, fvs;
   logic [2:0] errs;
   logic [1:0] fcs;
   // d0: WIDTH=4 CHANNELS=4 SETTLE=0
   logic busy0, done0, pass0, fv0;
   logic [7:0] err0;
   logic [1:0] fc0;

   scope_checker #(.WIDTH(1), .CHANNELS(2), .SETTLE(1), .CHECK_CYCLES(4), .CNT_W(8)) d1 (
      .clk(clk), .rst(rst), .start(start1), .obs(obs_v[1:0]), .exp(exp_v[1:0]),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
      .first_chan(fc1), .first_valid(fv1));

   scope_checker #(.WIDTH(4), .CHANNELS(4), .SETTLE(1), .CHECK_CYCLES(4), .CNT_W(8)) d4 (
      .clk(clk), .rst(rst), .start(start4), .obs(obs_v), .exp(exp_v),
      .busy(busy4), .done(done4), .pass(pass4), .err_count(err4),
      .first_chan(fc4), .first_valid(fv4));

   scope_checker #(.WIDTH(4), .CHANNELS(4), .SETTLE(1), .CHECK_CYCLES(4), .CNT_W(3)) ds (
      .clk(clk), .rst(rst), .start(start4), .obs(obs_v), .exp(exp_v),
      .busy(busys), .done(dones), .pass(passs), .err_count(errs),
      .first_chan(fcs), .first_valid(fvs));

   scope_checker #(.WIDTH(4), .CHANNELS(4), .SETTLE(0), .CHECK_CYCLES(4), .CNT_W(8)) d0 (
      .clk(clk), .rst(rst), .start(start0), .obs(obs_v), .exp(exp_v),
      .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
      .first_chan(fc0), .first_valid(fv0));

   int dc1 = 0, dc4 = 0, dc0 = 0;
   always @(posedge clk) if (done1) dc1 <= dc1 + 1;
   always @(posedge clk) if (done4) dc4 <= dc4 + 1;
   always @(posedge clk) if (done0) dc0 <= dc0 + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic set_start(input int which, input logic v);
      case (which)
         0:       start1 = v;
         1:       start4 = v;
         default: start0 = v;
      endcase
   endtask

   function automatic logic dn(input int which);
      case (which)
         0:       return done1;
         1:       return done4;
         default: return done0;
      endcase
   endfunction

   function automatic logic bz(input int which);
      case (which)
         0:       return busy1;
         1:       return busy4;
         default: return busy0;
      endcase
   endfunction

   function automatic int dcount(input int which);
      case (which)
         0:       return dc1;
         1:       return dc4;
         default: return dc0;
      endcase
   endfunction

   // Reference: walk the sampled cycles, compare each channel bit by bit,
   // count mismatching channel-samples and note the first one seen.
   task automatic model(input logic [3:0][15:0] ov, input logic [3:0][15:0] ev,
                        input int nch, input int w,
                        output int err, output int fc, output int fv);
      err = 0; fc = 0; fv = 0;
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < nch; i++) begin
            bit mis;
            mis = 1'b0;
            for (int b = 0; b < w; b++)
               if (ov[k][i*w+b] !== ev[k][i*w+b]) mis = 1'b1;
            if (mis) begin
               err++;
               if (fv == 0) begin fc = i; fv = 1; end
            end
         end
      end
   endtask

   function automatic int sat(input int v, input int bits);
      int m;
      m = (1 << bits) - 1;
      return (v > m) ? m : v;
   endfunction

   // One run: start, feed the 4 sampled cycles, check latency, single done
   // pulse, and that a start during the done pulse is ignored.
   task automatic run(input int which, input logic [3:0][15:0] ov,
                      input logic [3:0][15:0] ev, input int restart_k);
      int s, lat, dc_before;
      bit seen;
      s = (which == 2) ? 0 : 1;
      dc_before = dcount(which);
      @(negedge clk);
      obs_v = ev[0]; exp_v = ev[0];
      set_start(which, 1'b1);
      @(posedge clk);
      repeat (s) begin
         @(negedge clk);
         set_start(which, 1'b0);
         @(posedge clk);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         set_start(which, k == restart_k);
         obs_v = ov[k]; exp_v = ev[k];
         @(posedge clk);
      end
      @(negedge clk);
      set_start(which, 1'b0);
      obs_v = ev[3]; exp_v = ev[3];
      lat = s + 4;
      seen = 1'b0;
      for (int t = 0; t < 6; t++) begin
         if (dn(which)) begin seen = 1'b1; break; end
         @(negedge clk);
         lat++;
      end
      chk("done_seen", int'(seen), 1);
      chk("latency", lat, s + 5);
      set_start(which, 1'b1);
      @(negedge clk);
      set_start(which, 1'b0);
      chk("done_one_cycle", int'(dn(which)), 0);
      chk("start_in_done_ignored", int'(bz(which)), 0);
      chk("done_count", dcount(which) - dc_before, 1);
   endtask

   task automatic check_d4(input string tag, input int err, input int fc,
                           input int fv, input int ps, input int serr);
      chk({tag, "_err"}, int'(err4), err);
      chk({tag, "_pass"}, int'(pass4), ps);
      chk({tag, "_fv"}, int'(fv4), fv);
      if (fv != 0) chk({tag, "_fc"}, int'(fc4), fc);
      chk({tag, "_sat_err"}, int'(errs), serr);
      chk({tag, "_sat_pass"}, int'(passs), ps);
   endtask

   typedef struct {
      logic [3:0][15:0] ov;
      logic [3:0][15:0] ev;
      int err;
      int fc;
      int fv;
      int ps;
      int serr;
   } vec_t;

   vec_t tbl[6];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0][15:0] ov, ev;
      int e, f, v;

      for (int k = 0; k < 4; k++) begin
         tbl[0].ov[k] = 16'h1234; tbl[0].ev[k] = 16'h1234;
         tbl[1].ev[k] = 16'h1234; tbl[1].ov[k] = (k == 1 || k == 2) ? 16'h1A34 : 16'h1234;
         tbl[2].ev[k] = 16'h1234; tbl[2].ov[k] = 16'hF2F4;
         tbl[3].ev[k] = 16'h1234; tbl[3].ov[k] = 16'hEDCB;
         tbl[4].ev[k] = 16'h1234;
         tbl[4].ov[k] = (k == 0) ? 16'h9234 : ((k == 1) ? 16'h1235 : 16'h1234);
         tbl[5].ev[k] = 16'h0000; tbl[5].ov[k] = 16'h0000;
      end
      tbl[0].err = 0;  tbl[0].fc = 0; tbl[0].fv = 0; tbl[0].ps = 1; tbl[0].serr = 0;
      tbl[1].err = 2;  tbl[1].fc = 2; tbl[1].fv = 1; tbl[1].ps = 0; tbl[1].serr = 2;
      tbl[2].err = 8;  tbl[2].fc = 1; tbl[2].fv = 1; tbl[2].ps = 0; tbl[2].serr = 7;
      tbl[3].err = 16; tbl[3].fc = 0; tbl[3].fv = 1; tbl[3].ps = 0; tbl[3].serr = 7;
      tbl[4].err = 2;  tbl[4].fc = 3; tbl[4].fv = 1; tbl[4].ps = 0; tbl[4].serr = 2;
      tbl[5].err = 0;  tbl[5].fc = 0; tbl[5].fv = 0; tbl[5].ps = 1; tbl[5].serr = 0;

      rst = 1'b1;
      start1 = 1'b0; start4 = 1'b0; start0 = 1'b0;
      obs_v = '0; exp_v = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", int'(busy4), 0);
      chk("rst_done", int'(done4), 0);
      chk("rst_pass", int'(pass4), 0);
      chk("rst_err", int'(err4), 0);
      chk("rst_fv", int'(fv4), 0);
      chk("rst_fc", int'(fc4), 0);
      rst = 1'b0;
      @(negedge clk);

      // Single-bit two-channel run, everything matching.
      for (int k = 0; k < 4; k++) begin ov[k] = 16'h0002; ev[k] = 16'h0002; end
      run(0, ov, ev, -1);
      chk("w1_pass", int'(pass1), 1);
      chk("w1_err", int'(err1), 0);
      chk("w1_fv", int'(fv1), 0);

      // Single-bit run with channel 1 wrong in the last sampled cycle.
      ov[3] = 16'h0000;
      model(ov, ev, 2, 1, e, f, v);
      run(0, ov, ev, -1);
      chk("w1b_err", int'(err1), e);
      chk("w1b_fc", int'(fc1), f);
      chk("w1b_fv", int'(fv1), v);
      chk("w1b_pass", int'(pass1), int'(e == 0));

      // Table of 4x4 runs.
      for (int t = 0; t < 6; t++) begin
         run(1, tbl[t].ov, tbl[t].ev, -1);
         check_d4($sformatf("tbl%0d", t), tbl[t].err, tbl[t].fc, tbl[t].fv,
                  tbl[t].ps, tbl[t].serr);
      end

      // Unknown value on channel 0 against an expected 0.
      for (int k = 0; k < 4; k++) begin ov[k] = 16'h0000; ev[k] = 16'h0000; end
      ov[0] = {15'h0000, 1'bx};
      model(ov, ev, 4, 4, e, f, v);
      run(1, ov, ev, -1);
      check_d4("xval", e, f, v, int'(e == 0), sat(e, 3));

      // SETTLE=0 with a second start in the middle of CHECK.
      for (int k = 0; k < 4; k++) begin ov[k] = 16'h5A5A; ev[k] = 16'h5A5A; end
      run(2, ov, ev, 1);
      chk("s0_pass", int'(pass0), 1);
      chk("s0_err", int'(err0), 0);
      ov[2] = 16'h5A50;
      model(ov, ev, 4, 4, e, f, v);
      run(2, ov, ev, -1);
      chk("s0b_err", int'(err0), e);
      chk("s0b_fc", int'(fc0), f);
      chk("s0b_pass", int'(pass0), int'(e == 0));

      // Reset in the middle of a failing run.
      begin
         int dcb;
         dcb = dc4;
         @(negedge clk);
         obs_v = 16'hFFFF; exp_v = 16'h0000; start4 = 1'b1;
         @(negedge clk);
         start4 = 1'b0;
         repeat (3) @(negedge clk);
         chk("pre_reset_err_nonzero", int'(err4 != 0), 1);
         chk("pre_reset_busy", int'(busy4), 1);
         rst = 1'b1;
         #1;
         chk("mid_rst_busy", int'(busy4), 0);
         chk("mid_rst_err", int'(err4), 0);
         chk("mid_rst_fv", int'(fv4), 0);
         chk("mid_rst_fc", int'(fc4), 0);
         chk("mid_rst_pass", int'(pass4), 0);
         chk("mid_rst_done", int'(done4), 0);
         @(negedge clk);
         rst = 1'b0;
         obs_v = '0;
         repeat (10) @(negedge clk);
         chk("mid_rst_no_done", dc4 - dcb, 0);
      end

      // Following run passes normally.
      run(1, tbl[0].ov, tbl[0].ev, -1);
      check_d4("after_rst", 0, 0, 0, 1, 0);

      // Randomized runs against the reference model.
      for (int r = 0; r < 20; r++) begin
         for (int k = 0; k < 4; k++) begin
            logic [15:0] m;
            m = '0;
            ev[k] = 16'($urandom);
            for (int i = 0; i < 4; i++)
               if ($urandom_range(3) == 0) m[i*4 +: 4] = 4'($urandom_range(15, 1));
            ov[k] = ev[k] ^ m;
         end
         model(ov, ev, 4, 4, e, f, v);
         run(1, ov, ev, -1);
         check_d4($sformatf("rnd%0d", r), e, f, v, int'(e == 0), sat(e, 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
